axi_rd_mem_slave: RTL and testbench
===================================

Name: axi_rd_mem_slave

Overview:
- AXI4 read-only memory slave that sits directly downstream of the core's AR/R channels.
- Accepts one read burst at a time, generates beat addresses for FIXED, INCR and WRAP bursts, and returns 64-bit beats from a word-addressed array with RRESP/RLAST.
- Provides a backdoor preload port so the testbench can initialise program/data images.
- Serves as the co-simulation memory for instruction fetch and loads.

Parameters:
- MEM_BASE, 32'h8000_0000, byte address of array word 0.
- MEM_WORDS, 4096, depth in 64-bit words; power of two.
- IDW, 1, width of arid/rid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- arid  in  IDW  read ID
- araddr  in  32  start byte address
- arlen  in  8  beats-1
- arsize  in  3  log2 bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arlock/arcache/arprot/arqos/arregion  in  1/4/3/4/4  accepted, ignored
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  IDW  echoed arid
- rdata  out  64  read data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rlast  out  1  final beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- ld_en  in  1  backdoor write strobe
- ld_idx  in  $clog2(MEM_WORDS)  word index
- ld_data  in  64  backdoor data

Behaviour:
- Reset (sync, active-high): FSM to IDLE. arready=0 during reset, 1 in IDLE after reset. rvalid=0, rlast=0, rresp=0, rid=0, rdata=0. Array contents are not reset.
- FSM states:
  - IDLE: arready=1. On arvalid&arready, latch id/addr/len/size/burst, set beat counter to 0, go to FETCH.
  - FETCH: arready=0. Issue a synchronous array read of the current beat address. Go to DATA next cycle.
  - DATA: rvalid=1 with rdata/rresp/rlast registered and stable until handshake. On rready: if rlast, go to IDLE; else advance the address, increment the counter, and go to FETCH. Without rready, hold all R outputs.
- Latency and throughput: AR handshake at cycle T gives first rvalid at T+2. Consecutive beats are 2 cycles apart when rready is held high. A new AR can be accepted the cycle after the last-beat handshake.
- rlast=1 exactly when beat counter == latched len.
- Address generation uses a 32-bit byte address; nbytes = 1<<size.
  - FIXED: address constant for all beats.
  - INCR: beat 0 uses the unaligned start address; subsequent beats use the aligned address + n*nbytes. Wrap at 2^32 is modulo, with no error.
  - WRAP: container = (len+1)*nbytes; low bits wrap within the container-aligned block.
- Array index = (addr - MEM_BASE) >> 3. Narrow beats return the full containing doubleword; the master selects lanes.
- rresp per beat, with priority:
  1. SLVERR for every beat of the burst if any of: arsize>3, arburst==11, or WRAP with len not in {1,3,7,15}.
  2. Otherwise DECERR for a beat whose address is < MEM_BASE or >= MEM_BASE+8*MEM_WORDS.
  3. Otherwise OKAY.
- rdata is 0 on any non-OKAY beat. The burst always completes with len+1 beats.
- Backdoor load: a write on ld_en takes effect at the clock edge. If it occurs in the same cycle as a FETCH read of the same index, the read returns the old data (read-before-write).
- Reset mid-burst: R outputs drop to 0 next cycle and the burst is abandoned with no further beats.

Decomposition:
- riscv_core_pkg additions:
  - axi_burst_e (FIXED/INCR/WRAP/RSVD)
  - axi_resp_e (OKAY/EXOKAY/SLVERR/DECERR)
  - rd_state_e (IDLE/FETCH/DATA)
  - function axi_next_addr(addr, size, len, burst)
- One sub-module: mem_array_1r1w, a 64-bit x MEM_WORDS synchronous-read array with the backdoor write port.

Test Plan:
- Preload idx0..3 = 64'h11..44, then INCR araddr=8000_0000 len=3 size=3 with rready=1 -> 4 beats 11,22,33,44 OKAY; rlast only on the 4th beat; first rvalid 2 cycles after AR.
- WRAP araddr=8000_0010 len=3 size=3 -> beat indices 2,3,0,1; rlast on the 4th beat.
- FIXED araddr=8000_0008 len=2 -> word1 returned 3 times; rid echoes arid=1.
- araddr=7FFF_FFF8 INCR len=1 -> beat0 DECERR with rdata 0, beat1 (8000_0000) OKAY with data 11; arsize=4 -> all beats SLVERR.
- Hold rready=0 for 5 cycles on beat 1 -> rvalid/rdata/rlast stable; arready stays 0 until the final handshake.
- Assert rst in DATA of a len=7 burst -> rvalid=0 next cycle; after release a new AR is accepted and returns correct data.

Source files
------------

// File: rtl/axi_rd_mem_slave_pkg.sv
// Shared types and address-sequencing helper for the AXI4 read-only memory slave.
package axi_rd_mem_slave_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StData
  } rd_state_e;

  // Address of the beat following addr; only the first INCR beat may be unaligned.
  function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                input logic [2:0]  size,
                                                input logic [7:0]  len,
                                                input axi_burst_e  burst);
    logic [31:0] nbytes;
    logic [31:0] aligned;
    logic [31:0] incr;
    logic [31:0] wrap_mask;
    nbytes    = 32'd1 << size;
    aligned   = addr & ~(nbytes - 32'd1);
    incr      = aligned + nbytes;
    wrap_mask = (({24'd0, len} + 32'd1) * nbytes) - 32'd1;
    case (burst)
      BurstFixed: axi_next_addr = addr;
      BurstWrap:  axi_next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:    axi_next_addr = incr;
    endcase
  endfunction

endpackage

// File: rtl/axi_rd_mem_slave_mem_array_1r1w.sv
// 64-bit synchronous-read word array with an independent backdoor write port.
// A read and write of the same index in one cycle returns the old contents.
module mem_array_1r1w #(
  parameter int unsigned MEM_WORDS = 4096,
  localparam int unsigned IDXW = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            rd_en,
  input  logic [IDXW-1:0] rd_idx,
  output logic [63:0]     rd_data,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [63:0]     wr_data
);

  logic [63:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/axi_rd_mem_slave.sv
// AXI4 read-only memory slave: one burst at a time, FIXED/INCR/WRAP sequencing,
// one beat every two cycles, backdoor preload port.
module axi_rd_mem_slave
  import axi_rd_mem_slave_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned IDW       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDW-1:0]               arid,
  input  logic [31:0]                  araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arlock,
  input  logic [3:0]                   arcache,
  input  logic [2:0]                   arprot,
  input  logic [3:0]                   arqos,
  input  logic [3:0]                   arregion,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [IDW-1:0]               rid,
  output logic [63:0]                  rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_idx,
  input  logic [63:0]                  ld_data
);

  localparam int unsigned IDXW     = $clog2(MEM_WORDS);
  localparam logic [31:0] MemBytes = 32'(MEM_WORDS * 8);

  rd_state_e   state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  axi_burst_e  burst_q, burst_d;
  logic        slverr_q, slverr_d;
  axi_resp_e   resp_q, resp_d;

  logic        wrap_len_ok;
  logic        ar_slverr;
  logic [31:0] offset;
  logic        in_range;
  logic        last_beat;
  logic [63:0] mem_rdata;
  logic        unused_ok;

  assign unused_ok = ^{arlock, arcache, arprot, arqos, arregion};

  // Protocol violations poison the whole burst, so decide them once at AR time.
  assign wrap_len_ok = arlen inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign ar_slverr   = (arsize > 3'd3) || (arburst == 2'b11) ||
                       ((arburst == 2'b10) && !wrap_len_ok);

  assign offset    = addr_q - MEM_BASE;
  assign in_range  = offset < MemBytes;
  assign last_beat = cnt_q == len_q;

  mem_array_1r1w #(
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .rd_en   (state_q == StFetch),
    .rd_idx  (offset[IDXW+2:3]),
    .rd_data (mem_rdata),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    burst_d  = burst_q;
    slverr_d = slverr_q;
    resp_d   = resp_q;
    unique case (state_q)
      StIdle: begin
        if (arvalid && arready) begin
          id_d     = arid;
          addr_d   = araddr;
          len_d    = arlen;
          size_d   = arsize;
          burst_d  = axi_burst_e'(arburst);
          slverr_d = ar_slverr;
          cnt_d    = 8'd0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        resp_d  = slverr_q ? RespSlverr : (in_range ? RespOkay : RespDecerr);
        state_d = StData;
      end
      StData: begin
        if (rready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            addr_d  = axi_next_addr(addr_q, size_q, len_q, burst_q);
            cnt_d   = cnt_q + 8'd1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= BurstFixed;
      slverr_q <= 1'b0;
      resp_q   <= RespOkay;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      slverr_q <= slverr_d;
      resp_q   <= resp_d;
    end
  end

  // R outputs are all sourced from registers and held while StData waits on rready.
  always_comb begin
    arready = (state_q == StIdle) && !rst;
    rvalid  = state_q == StData;
    rid     = rvalid ? id_q : '0;
    rresp   = rvalid ? resp_q : RespOkay;
    rlast   = rvalid && last_beat;
    rdata   = (rvalid && (resp_q == RespOkay)) ? mem_rdata : 64'd0;
  end

endmodule

// File: tb/tb_axi_rd_mem_slave.sv
// Self-checking bench for axi_rd_mem_slave: directed bursts plus randomized bursts
// checked against an arithmetic burst model and a shadow copy of the memory image.
module tb_axi_rd_mem_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned WORDS = 4096;
  localparam int unsigned IDXW  = 12;

  logic            clk;
  logic            rst;
  logic [0:0]      arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [0:0]      rid;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic            ld_en;
  logic [IDXW-1:0] ld_idx;
  logic [63:0]     ld_data;

  logic [63:0] model_mem [WORDS];
  int checks   = 0;
  int failures = 0;

  axi_rd_mem_slave #(
    .MEM_BASE  (BASE),
    .MEM_WORDS (WORDS),
    .IDW       (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arid     (arid),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .arlock   (1'b0),
    .arcache  (4'd0),
    .arprot   (3'd0),
    .arqos    (4'd0),
    .arregion (4'd0),
    .arvalid  (arvalid),
    .arready  (arready),
    .rid      (rid),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready),
    .ld_en    (ld_en),
    .ld_idx   (ld_idx),
    .ld_data  (ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst,
                                            input int n);
    longint nbytes;
    longint container;
    logic [31:0] aligned;
    logic [31:0] lower;
    nbytes  = longint'(1) << size;
    aligned = start & ~32'(nbytes - 1);
    case (burst)
      2'b00: return start;
      2'b10: begin
        container = (longint'(len) + 1) * nbytes;
        lower     = start & ~32'(container - 1);
        return lower + 32'((longint'(aligned - lower) + longint'(n) * nbytes) % container);
      end
      default: return (n == 0) ? start : aligned + 32'(longint'(n) * nbytes);
    endcase
  endfunction

  function automatic logic [1:0] exp_resp(input logic [2:0] size, input logic [7:0] len,
                                          input logic [1:0] burst, input logic [31:0] a);
    if (size > 3 || burst == 2'b11 ||
        (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)))
      return 2'b10;
    if (longint'(a) < longint'(BASE) || longint'(a) >= longint'(BASE) + 8 * longint'(WORDS))
      return 2'b11;
    return 2'b00;
  endfunction

  // hold_beat: stall that beat 5 cycles; rst_beat: assert reset while that beat is
  // presented; bd_fetch: backdoor-write beat 0's word during its array read.
  task automatic do_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall_pct,
                          input int hold_beat, input int rst_beat, input bit bd_fetch);
    logic [31:0] a;
    logic [31:0] widx;
    logic [1:0]  er;
    logic [63:0] ed;
    int waits;
    int hold;
    bit got;
    @(negedge clk);
    check("arready_idle", arready, 1);
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    @(posedge clk);
    #1 arvalid = 1'b0;
    for (int n = 0; n <= int'(len); n++) begin
      a    = beat_addr(addr, size, len, burst, n);
      er   = exp_resp(size, len, burst, a);
      widx = (a - BASE) >> 3;
      ed   = (er == 2'b00) ? model_mem[widx[IDXW-1:0]] : 64'd0;
      hold = (n == hold_beat) ? 5 : 0;
      waits = 0;
      got   = 1'b0;
      while (!got) begin
        @(negedge clk);
        ld_en = 1'b0;
        if (rvalid !== 1'b1) begin
          waits++;
          check("arready_busy", arready, 0);
          if (bd_fetch && n == 0 && waits == 1) begin
            ld_en   = 1'b1;
            ld_idx  = widx[IDXW-1:0];
            ld_data = ~ed;
            model_mem[widx[IDXW-1:0]] = ~ed;
          end
          if (waits > 3) begin
            check("beat_timeout", rvalid, 1);
            return;
          end
        end else begin
          check("beat_latency", waits, 1);
          check("rid", rid, id);
          check("rdata", rdata, ed);
          check("rresp", rresp, er);
          check("rlast", rlast, (n == int'(len)) ? 1 : 0);
          check("arready_busy", arready, 0);
          if (n == rst_beat) begin
            rst    = 1'b1;
            rready = 1'b0;
            @(negedge clk);
            check("rst_rvalid", rvalid, 0);
            check("rst_rdata", rdata, 0);
            check("rst_rresp", rresp, 0);
            check("rst_rlast", rlast, 0);
            check("rst_rid", rid, 0);
            check("rst_arready", arready, 0);
            rst = 1'b0;
            return;
          end
          if (hold > 0) begin
            rready = 1'b0;
            hold--;
          end else begin
            rready = ($urandom_range(99) >= stall_pct);
          end
          if (rready) got = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [1:0]  rb;
    logic [2:0]  rs;
    logic [7:0]  rl;
    logic [31:0] ra;
    rst     = 1'b1;
    arid    = '0;
    araddr  = '0;
    arlen   = '0;
    arsize  = '0;
    arburst = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    ld_en   = 1'b0;
    ld_idx  = '0;
    ld_data = '0;
    repeat (3) @(negedge clk);
    check("reset_arready", arready, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_rlast", rlast, 0);
    check("reset_rresp", rresp, 0);
    check("reset_rid", rid, 0);
    check("reset_rdata", rdata, 0);

    for (int i = 0; i < int'(WORDS); i++) begin
      ld_en   = 1'b1;
      ld_idx  = IDXW'(i);
      ld_data = (i < 4) ? 64'(i + 1) * 64'h11 : {$urandom, $urandom};
      model_mem[i] = ld_data;
      @(negedge clk);
    end
    ld_en = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("idle_arready", arready, 1);

    do_burst(1'b0, BASE, 8'd3, 3'd3, 2'b01, 0, -1, -1, 1'b0);
    do_burst(1'b0, BASE + 32'h10, 8'd3, 3'd3, 2'b10, 0, -1, -1, 1'b0);
    do_burst(1'b1, BASE + 32'h8, 8'd2, 3'd3, 2'b00, 0, -1, -1, 1'b0);
    do_burst(1'b0, 32'h7FFF_FFF8, 8'd1, 3'd3, 2'b01, 0, -1, -1, 1'b0);
    do_burst(1'b1, BASE, 8'd2, 3'd4, 2'b01, 0, -1, -1, 1'b0);
    do_burst(1'b0, BASE, 8'd3, 3'd3, 2'b01, 0, 1, -1, 1'b0);
    do_burst(1'b1, BASE + 32'h40, 8'd7, 3'd3, 2'b01, 0, -1, 3, 1'b0);
    do_burst(1'b0, BASE, 8'd3, 3'd3, 2'b01, 0, -1, -1, 1'b0);
    do_burst(1'b0, BASE + 32'h28, 8'd1, 3'd3, 2'b00, 0, -1, -1, 1'b1);
    do_burst(1'b1, 32'hFFFF_FFF0, 8'd3, 3'd3, 2'b01, 0, -1, -1, 1'b0);
    do_burst(1'b0, BASE + 32'h3, 8'd9, 3'd0, 2'b01, 0, -1, -1, 1'b0);
    do_burst(1'b0, BASE + 32'h20, 8'd2, 3'd3, 2'b10, 0, -1, -1, 1'b0);
    do_burst(1'b1, BASE, 8'd1, 3'd2, 2'b11, 0, -1, -1, 1'b0);
    do_burst(1'b0, BASE + 32'(8 * WORDS) - 32'd8, 8'd1, 3'd3, 2'b01, 0, -1, -1, 1'b0);

    for (int k = 0; k < 60; k++) begin
      rb = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2));
      rs = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
      if (rb == 2'b10 && $urandom_range(7) != 0)
        rl = 8'((2 << $urandom_range(3)) - 1);
      else
        rl = 8'($urandom_range(15));
      ra = BASE - 32'd64 + 32'($urandom_range(8 * WORDS + 128));
      if (rb == 2'b10) ra = ra & ~((32'd1 << rs) - 32'd1);
      do_burst(1'($urandom_range(1)), ra, rl, rs, rb, int'($urandom_range(50)), -1, -1, 1'b0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
